// File: rtl/life_pkg.sv
// Shared constants and the per-cell rule for the Game-of-Life board engine.
// The board width/height defaults and the neighbour-count width live here.
package life_pkg;

   localparam int LIFE_LOG2 = 3;
   localparam int NCNT_W    = 4;

   localparam logic [NCNT_W-1:0] SURVIVE_N = 4'd2;
   localparam logic [NCNT_W-1:0] BIRTH_N   = 4'd3;

   // Birth on exactly three neighbours, survival on two or three.
   function automatic logic cell_next(input logic alive, input logic [NCNT_W-1:0] n);
      return (n == BIRTH_N) || (alive && (n == SURVIVE_N));
   endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation evaluator for one board row.
// Horizontal neighbours wrap around, so column 0 sees column X-1.
module life_row_next
   import life_pkg::*;
#(
   parameter int X = 8
) (
   input  logic [X-1:0] above_i,
   input  logic [X-1:0] cur_i,
   input  logic [X-1:0] below_i,
   output logic [X-1:0] next_o
);

   for (genvar c = 0; c < X; c++) begin : g_col
      localparam int CL = (c + X - 1) % X;
      localparam int CR = (c + 1) % X;

      logic [NCNT_W-1:0] n;

      assign n = NCNT_W'(above_i[CL]) + NCNT_W'(above_i[c]) + NCNT_W'(above_i[CR])
               + NCNT_W'(cur_i[CL])                         + NCNT_W'(cur_i[CR])
               + NCNT_W'(below_i[CL]) + NCNT_W'(below_i[c]) + NCNT_W'(below_i[CR]);

      assign next_o[c] = cell_next(cur_i[c], n);
   end

endmodule

// File: rtl/life_board.sv
// Toroidal Game-of-Life board held in a rotating row ring, with the display scan counter.
// One generation is computed in place per frame, one row per row-slot, without stalling the scan.
module life_board
   import life_pkg::*;
#(
   parameter int X              = 8,
   parameter int Y              = 8,
   parameter int LOG2X          = LIFE_LOG2,
   parameter int LOG2Y          = LIFE_LOG2,
   parameter int FRAMES_PER_GEN = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   step,
   input  logic                   seed_wr,
   input  logic [LOG2Y-1:0]       seed_addr,
   input  logic [X-1:0]           seed_row,
   output logic [X-1:0]           top_row,
   output logic [LOG2X+LOG2Y-1:0] cnt,
   output logic                   busy,
   output logic [15:0]            generation
);

   localparam int CW = LOG2X + LOG2Y;
   localparam int FW = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [X-1:0]     ring_q [Y];
   logic [X-1:0]     ring_d [Y];
   logic [0:0]       state_q, state_d;
   logic             pending_q, pending_d;
   logic [FW-1:0]    frame_q, frame_d;
   logic [X-1:0]     prev_old_q, prev_old_d;
   logic [X-1:0]     first_old_q, first_old_d;
   logic [15:0]      gen_q, gen_d;

   logic [LOG2Y-1:0] row_idx;
   logic [LOG2Y-1:0] seed_slot;
   logic             rotate;
   logic             wrap;
   logic             pass_on;
   logic             pass_start;
   logic             frame_fire;
   logic             seed_ok;
   logic [X-1:0]     below_row;
   logic [X-1:0]     next_row;

   assign row_idx    = cnt_q[CW-1:LOG2X];
   assign rotate     = &cnt_q[LOG2X-1:0];
   assign wrap       = &cnt_q;
   assign pass_on    = (state_q == S_BUSY);
   assign pass_start = wrap & pending_q;
   assign frame_fire = wrap & run & (frame_q == FW'(FRAMES_PER_GEN - 1));
   assign seed_ok    = seed_wr & ~pass_on & ~pass_start;

   // Slot p holds logical row (row_idx + p); a rotate edge shifts that mapping by one.
   assign seed_slot  = seed_addr - row_idx - LOG2Y'(rotate);

   // The last row's lower neighbour is row 0, which was already overwritten this pass.
   assign below_row  = (&row_idx) ? first_old_q : ring_q[1];

   life_row_next #(
      .X(X)
   ) u_row_next (
      .above_i(prev_old_q),
      .cur_i  (ring_q[0]),
      .below_i(below_row),
      .next_o (next_row)
   );

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path leaves one unassigned and no latch appears.
      cnt_d       = cnt_q + CW'(1);
      state_d     = state_q;
      pending_d   = (pending_q & ~pass_start) | step | frame_fire;
      frame_d     = frame_q;
      prev_old_d  = prev_old_q;
      first_old_d = first_old_q;
      gen_d       = gen_q;
      ring_d      = ring_q;

      if (wrap && run) begin
         frame_d = frame_fire ? '0 : frame_q + FW'(1);
      end

      if (rotate) begin
         for (int i = 0; i < Y - 1; i++) begin
            ring_d[i] = ring_q[i + 1];
         end
         ring_d[Y-1] = pass_on ? next_row : ring_q[0];
         if (pass_on) begin
            prev_old_d = ring_q[0];
            if (row_idx == '0) begin
               first_old_d = ring_q[0];
            end
         end
      end

      if (wrap) begin
         state_d = pending_q ? S_BUSY : S_IDLE;
         if (pass_on) begin
            gen_d = gen_q + 16'd1;
         end
      end

      // Back-to-back passes: row Y-1 of the new generation is the row written to the tail right now.
      if (pass_start) begin
         prev_old_d = pass_on ? next_row : ring_q[0];
      end

      if (seed_ok) begin
         ring_d[seed_slot] = seed_row;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q       <= '0;
         state_q     <= S_IDLE;
         pending_q   <= 1'b0;
         frame_q     <= '0;
         prev_old_q  <= '0;
         first_old_q <= '0;
         gen_q       <= '0;
         // NOTE: the ring is ordinary flops, cleared on reset so an abandoned pass leaves a blank board.
         for (int i = 0; i < Y; i++) begin
            ring_q[i] <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         state_q     <= state_d;
         pending_q   <= pending_d;
         frame_q     <= frame_d;
         prev_old_q  <= prev_old_d;
         first_old_q <= first_old_d;
         gen_q       <= gen_d;
         ring_q      <= ring_d;
      end
   end

   assign top_row    = ring_q[0];
   assign cnt        = cnt_q;
   assign busy       = pass_on;
   assign generation = gen_q;

endmodule
